// File: rtl/branch_resolve.sv
// Branch resolution: mispredict detection, redirect/flush generation, and a
// direct-mapped BTB with 2-bit counters looked up combinationally by fetch.
module branch_resolve #(
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] if_pc,
  output logic        bp_taken,
  output logic [63:0] bp_target,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [63:0] ex_pc,
  input  logic        ex_is_jump,
  input  logic        ex_bboolean,
  input  logic [63:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [63:0] ex_pred_target,
  input  logic        fetch_ready,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        flush,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = 64 - IDX_W - 2;

  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [63:0]        btb_target [ENTRIES];
  logic [1:0]         btb_ctr    [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;

  logic        resolve;
  logic        actual_taken;
  logic [63:0] next_pc;
  logic        mispredict;
  logic        ex_hit;
  logic        wr_en;
  logic        wr_entry;
  logic [1:0]  wr_ctr;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[63:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[63:IDX_W+2];

  // Fetch-side lookup; sees the table as of the last clock edge.
  always_comb begin
    bp_taken  = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag) && btb_ctr[if_idx][1];
    bp_target = bp_taken ? btb_target[if_idx] : if_pc + 64'd4;
  end

  // Wrong-path instructions behind a pending redirect never resolve.
  always_comb begin
    resolve      = ex_valid && !ex_stall && !redirect_valid;
    actual_taken = ex_is_jump || ex_bboolean;
    next_pc      = actual_taken ? ex_target : ex_pc + 64'd4;
    mispredict   = (actual_taken != ex_pred_taken) ||
                   (actual_taken && ex_pred_taken && (ex_target != ex_pred_target));
    ex_hit       = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
  end

  // Table write decision: counter training on hit, allocation on taken miss.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = 1'b0;
    wr_ctr   = btb_ctr[ex_idx];
    if (resolve) begin
      if (ex_hit) begin
        wr_en = 1'b1;
        if (ex_is_jump) begin
          wr_ctr   = 2'd3;
          wr_entry = 1'b1;
        end else if (ex_bboolean) begin
          wr_ctr   = (btb_ctr[ex_idx] == 2'd3) ? 2'd3 : btb_ctr[ex_idx] + 2'd1;
          wr_entry = 1'b1;
        end else begin
          wr_ctr   = (btb_ctr[ex_idx] == 2'd0) ? 2'd0 : btb_ctr[ex_idx] - 2'd1;
        end
      end else if (actual_taken) begin
        wr_en    = 1'b1;
        wr_entry = 1'b1;
        wr_ctr   = ex_is_jump ? 2'd3 : 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'd1;
      end
    end else if (wr_en) begin
      btb_ctr[ex_idx] <= wr_ctr;
      if (wr_entry) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= ex_target;
      end
    end
  end

  // Redirect/flush and statistics; a redirect holds until fetch takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      br_count       <= '0;
      mispred_count  <= '0;
    end else begin
      flush <= resolve && mispredict;
      if (resolve) begin
        br_count <= br_count + 32'd1;
      end
      if (resolve && mispredict) begin
        mispred_count  <= mispred_count + 32'd1;
        redirect_valid <= 1'b1;
        redirect_pc    <= next_pc;
      end else if (redirect_valid && fetch_ready) begin
        redirect_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;

  logic        clk;
  logic        reset;
  logic [63:0] if_pc;
  logic        bp_taken;
  logic [63:0] bp_target;
  logic        ex_valid;
  logic        ex_stall;
  logic [63:0] ex_pc;
  logic        ex_is_jump;
  logic        ex_bboolean;
  logic [63:0] ex_target;
  logic        ex_pred_taken;
  logic [63:0] ex_pred_target;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int checks   = 0;
  int failures = 0;
  int exp_br   = 0;
  int exp_mis  = 0;

  branch_resolve #(.IDX_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .bp_taken       (bp_taken),
    .bp_target      (bp_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_pc          (ex_pc),
    .ex_is_jump     (ex_is_jump),
    .ex_bboolean    (ex_bboolean),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [63:0] pc, input logic exp_t,
                      input logic [63:0] exp_tg);
    if_pc = pc;
    #1;
    chk({tag, "_bp_taken"}, 64'(bp_taken), 64'(exp_t));
    chk({tag, "_bp_target"}, bp_target, exp_tg);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_br_count"}, 64'(br_count), 64'(exp_br));
    chk({tag, "_mispred_count"}, 64'(mispred_count), 64'(exp_mis));
  endtask

  // One resolving cycle; afterwards the bench sits in the following cycle.
  task automatic do_resolve(input string tag, input logic [63:0] pc, input logic jump,
                            input logic bb, input logic [63:0] tgt, input logic pt,
                            input logic [63:0] ptg, input logic exp_mp,
                            input logic [63:0] exp_rpc);
    ex_valid = 1'b1; ex_stall = 1'b0; ex_pc = pc; ex_is_jump = jump;
    ex_bboolean = bb; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
    step();
    ex_valid = 1'b0;
    exp_br++;
    if (exp_mp) exp_mis++;
    chk({tag, "_flush"}, 64'(flush), 64'(exp_mp));
    chk({tag, "_redirect_valid"}, 64'(redirect_valid), 64'(exp_mp));
    if (exp_mp) chk({tag, "_redirect_pc"}, redirect_pc, exp_rpc);
    check_counts(tag);
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    fetch_ready = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0; ex_pc = '0;
    ex_is_jump = 1'b0; ex_bboolean = 1'b0; ex_target = '0; ex_pred_taken = 1'b0;
    ex_pred_target = '0; fetch_ready = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    look("rst", 64'h1000, 1'b0, 64'h1004);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    check_counts("rst");
    look("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

    // Taken branch predicted not-taken; same-cycle lookup still sees old entry
    look("old_entry", 64'h1000, 1'b0, 64'h1004);
    do_resolve("mp1", 64'h1000, 1'b0, 1'b1, 64'h0F00, 1'b0, 64'h0, 1'b1, 64'h0F00);
    look("mp1_new", 64'h1000, 1'b1, 64'h0F00);

    // Hold redirect while wrong-path branches sit in EX
    fetch_ready = 1'b0;
    ex_valid = 1'b1; ex_pc = 64'h3008; ex_is_jump = 1'b0; ex_bboolean = 1'b1;
    ex_target = 64'h3100; ex_pred_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_flush", 64'(flush), 64'd0);
      chk("hold_redirect_valid", 64'(redirect_valid), 64'd1);
      chk("hold_redirect_pc", redirect_pc, 64'h0F00);
      check_counts("hold");
    end
    look("hold_no_update", 64'h3008, 1'b0, 64'h300C);
    ex_valid = 1'b0;
    fetch_ready = 1'b1;
    step();
    chk("release_redirect_valid", 64'(redirect_valid), 64'd0);
    check_counts("release");

    // Tag conflict at index 0
    do_resolve("alias1", 64'h1040, 1'b0, 1'b1, 64'h5000, 1'b0, 64'h0, 1'b1, 64'h5000);
    idle();
    look("alias1_old", 64'h1000, 1'b0, 64'h1004);
    look("alias1_new", 64'h1040, 1'b1, 64'h5000);
    do_resolve("alias2", 64'h1080, 1'b0, 1'b0, 64'h7000, 1'b0, 64'h0, 1'b0, 64'h0);
    idle();
    look("alias2_keep", 64'h1040, 1'b1, 64'h5000);
    look("alias2_miss", 64'h1080, 1'b0, 64'h1084);

    // Saturation and hysteresis at 0x2000
    do_resolve("sat1", 64'h2000, 1'b0, 1'b1, 64'h2400, 1'b0, 64'h0, 1'b1, 64'h2400);
    idle();
    for (int i = 0; i < 3; i++) begin
      do_resolve("satn", 64'h2000, 1'b0, 1'b1, 64'h2400, 1'b1, 64'h2400, 1'b0, 64'h0);
      idle();
    end
    look("sat_trained", 64'h2000, 1'b1, 64'h2400);
    do_resolve("nt1", 64'h2000, 1'b0, 1'b0, 64'h2400, 1'b1, 64'h2400, 1'b1, 64'h2004);
    idle();
    look("nt1_hyst", 64'h2000, 1'b1, 64'h2400);
    do_resolve("nt2", 64'h2000, 1'b0, 1'b0, 64'h2400, 1'b1, 64'h2400, 1'b1, 64'h2004);
    idle();
    look("nt2_flip", 64'h2000, 1'b0, 64'h2004);

    // Stall blocks resolution
    ex_valid = 1'b1; ex_stall = 1'b1; ex_pc = 64'h3008; ex_is_jump = 1'b1;
    ex_bboolean = 1'b0; ex_target = 64'h3500; ex_pred_taken = 1'b1;
    ex_pred_target = 64'h3400;
    step();
    step();
    chk("stall_flush", 64'(flush), 64'd0);
    chk("stall_redirect_valid", 64'(redirect_valid), 64'd0);
    check_counts("stall");
    look("stall_no_update", 64'h3008, 1'b0, 64'h300C);

    // Unstall: jump with wrong predicted target
    do_resolve("jmp", 64'h3008, 1'b1, 1'b0, 64'h3500, 1'b1, 64'h3400, 1'b1, 64'h3500);
    look("jmp_new", 64'h3008, 1'b1, 64'h3500);

    // Reset drops the pending redirect
    fetch_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_br = 0;
    exp_mis = 0;
    chk("rst2_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst2_redirect_pc", redirect_pc, 64'd0);
    chk("rst2_flush", 64'(flush), 64'd0);
    check_counts("rst2");
    look("rst2", 64'h3008, 1'b0, 64'h300C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution and prediction block for the pipelined RV64 core. It sits directly downstream of the EX-stage branch comparator and consumes its taken/not-taken result together with the prediction carried down the pipe. When a branch or jump was mispredicted it raises a one-cycle pipeline flush and holds a PC redirect to fetch until fetch accepts it. It also owns a direct-mapped branch target buffer with 2-bit counters, which fetch looks up combinationally.

## Interface
- `IDX_W`, 4: BTB index width; entries = 2^IDX_W.
- `clk` in 1: clock.
- `reset` in 1: reset. One clock; reset is synchronous and active-high.
- `if_pc` in 64: fetch-stage PC for lookup.
- `bp_taken` out 1: predicted taken for `if_pc`.
- `bp_target` out 64: predicted next PC for `if_pc`.
- `ex_valid` in 1: a branch or jump occupies EX this cycle.
- `ex_stall` in 1: EX is held; nothing resolves this cycle.
- `ex_pc` in 64: PC of the EX instruction.
- `ex_is_jump` in 1: unconditional jump (jal/jalr).
- `ex_bboolean` in 1: comparator taken result.
- `ex_target` in 64: computed taken target.
- `ex_pred_taken` in 1: prediction carried from fetch.
- `ex_pred_target` in 64: predicted target carried from fetch.
- `fetch_ready` in 1: fetch accepts the redirect this cycle.
- `redirect_valid` out 1: redirect pending.
- `redirect_pc` out 64: correct next PC.
- `flush` out 1: kill IF/ID and ID/EX contents.
- `br_count` out 32: resolved control-transfer count.
- `mispred_count` out 32: mispredict count.

## Operation
- **Resolve condition:** `ex_valid & ~ex_stall & ~redirect_valid`.
  - A resolve while `redirect_valid`=1 is wrong-path and is ignored entirely: no table update, no count, no redirect.
- **Taken:** `actual_taken = ex_is_jump | ex_bboolean`.
- **Correct next PC:** `actual_taken ? ex_target : ex_pc+4`. The +4 is 64-bit and wraps modulo 2^64.
- **Mispredict:** `actual_taken != ex_pred_taken`, or both taken with `ex_target != ex_pred_target`.
- **On mispredict:** register `redirect_pc`, set `redirect_valid`, pulse `flush`.
- **Redirect handshake:**
  - `redirect_valid` holds, and `redirect_pc` stays stable, until a cycle with `fetch_ready`=1.
  - `redirect_valid` clears on the clock edge after that cycle.
- **BTB entry fields:** valid, tag = `pc[63:IDX_W+2]`, 64-bit target, 2-bit counter. Index = `pc[IDX_W+1:2]`.
- **Lookup (combinational):**
  - `bp_taken` = valid & tag match & counter[1].
  - `bp_target` = entry target if `bp_taken`, else `if_pc+4`.
- **Update on every resolve (hit):**
  - Jump: counter set to 3 and target rewritten.
  - Taken branch: counter saturates upward at 3 and target is rewritten.
  - Not-taken branch: counter saturates downward at 0.
- **Update on every resolve (miss or invalid):**
  - Taken: allocate with valid=1, the new tag and target, counter=2 (jump: 3).
  - Not-taken: no change.
- **Counters:**
  - `br_count` increments on every resolve.
  - `mispred_count` increments on every mispredict.
  - Both wrap from 2^32−1 to 0.

## Timing
- Lookup has 0-cycle latency from `if_pc`.
- A table write takes effect at the clock edge.
  - A lookup of the same index in the resolve cycle sees the old entry.
  - The next cycle sees the new entry.
- Mispredict resolve in cycle N:
  - `flush`=1 in cycle N+1 only.
  - `redirect_valid`=1 from N+1.
  - Earliest clear is N+2, when `fetch_ready`=1 in N+1.
- Counters update at the edge ending the resolve cycle.
- `ex_stall`=1 blocks resolution. The instruction resolves in the first cycle it is unstalled.
- **Reset (synchronous, active-high):**
  - All BTB valid bits cleared, counters set to 1.
  - `redirect_valid`=0, `redirect_pc`=0, `flush`=0, `br_count`=0, `mispred_count`=0.
  - `bp_taken`=0 and `bp_target`=`if_pc+4`.
  - Reset during a pending redirect drops it with no handshake.

## Test plan
- **Reset, then lookup:** reset, then `if_pc`=0x1000 → `bp_taken`=0, `bp_target`=0x1004, all outputs 0.
- **Taken branch, predicted not-taken:** `ex_pc`=0x1000, `ex_bboolean`=1, `ex_target`=0x0F00, `ex_pred_taken`=0.
  - Next cycle: `flush`=1 for one cycle, `redirect_pc`=0x0F00, `mispred_count`=1.
  - Lookup of 0x1000 then gives `bp_taken`=1 and `bp_target`=0x0F00.
- **Redirect hold and wrong-path ignore:** hold `fetch_ready`=0 for 3 cycles after a mispredict, with `ex_valid`=1 in those cycles.
  - `redirect_valid` and `redirect_pc` stay stable.
  - `br_count` does not advance.
  - `fetch_ready`=1 → `redirect_valid`=0 next cycle.
- **Counter saturation and hysteresis:** train 0x2000 taken 4 times, then not-taken once.
  - Prediction stays taken (counter 3→2).
  - The second not-taken makes the prediction not-taken.
- **Tag conflict:**
  - Allocate 0x1000 taken, then resolve taken at 0x1000+16·4 → entry replaced; lookup of 0x1000 gives `bp_taken`=0.
  - Not-taken at a third aliasing PC → no table change.
- **Stall, target mismatch and reset:**
  - `ex_stall`=1 with `ex_valid`=1 → no update.
  - Unstall with a jump where `ex_pred_taken`=1 and the target differs → mispredict and redirect.
  - Assert `reset` while the redirect is pending → `redirect_valid`=0 next cycle.
